// File: rtl/lcg_stim_sequencer.sv
// lcg_stim_sequencer: LCG-driven stimulus sequencer with DUT reset control and run-step budget.
// Optional response MISR enabled by defining LCG_STIM_SIGNATURE_EN.
module lcg_stim_sequencer #(
    parameter int          IN_W    = 265,
    parameter int          OUT_W   = 330,
    parameter int          CNT_W   = 32,
    parameter int          RST_CYC = 2,
    parameter logic [31:0] LCG_A   = 32'h41C64E6D,
    parameter logic [31:0] LCG_C   = 32'h3039
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] cycles,
    input  logic [OUT_W-1:0] out_flat,
    output logic [IN_W-1:0]  in_flat,
    output logic             dut_rst_n,
    output logic             vec_valid,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic             busy,
    output logic             done,
    output logic [31:0]      signature
);
    localparam int NWORDS = (IN_W + 31) / 32;
    localparam int IDX_W  = NWORDS > 1 ? $clog2(NWORDS) : 1;
    localparam int RC_W   = $clog2(RST_CYC + 1);

    typedef enum logic [2:0] {IDLE, RESET, FILL, APPLY, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      rng_q, rng_d, rng_next;
    logic [CNT_W-1:0] cyc_q, cyc_d, cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic [IN_W-1:0]  in_flat_q, in_flat_d, wr_mask, wr_data;
    logic             accept;

    assign rng_next = rng_q * LCG_A + LCG_C;
    assign accept   = start && (state_q == IDLE || state_q == DONE);
    // Shifting in IN_W width truncates the final partial word for free
    assign wr_mask  = IN_W'({32{1'b1}}) << (32 * idx_q);
    assign wr_data  = IN_W'(rng_next) << (32 * idx_q);

`ifdef LCG_STIM_SIGNATURE_EN
    localparam int OW = (OUT_W + 31) / 32;
    logic [31:0]     sig_q, sig_d, fold;
    logic [32*OW-1:0] out_pad;
    assign out_pad = (32 * OW)'(out_flat);
    always_comb begin
        fold = '0;
        for (int i = 0; i < OW; i++) fold = fold ^ out_pad[32*i +: 32];
    end
    assign signature = sig_q;
`else
    logic unused_out;
    assign unused_out = ^out_flat;
    assign signature  = '0;
`endif

    always_comb begin
        state_d   = state_q;
        rng_d     = rng_q;
        cyc_d     = cyc_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rcnt_d    = rcnt_q;
        in_flat_d = in_flat_q;
`ifdef LCG_STIM_SIGNATURE_EN
        sig_d     = sig_q;
`endif
        if (abort) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = RESET;
            rng_d   = seed;
            cyc_d   = cycles;
            cnt_d   = '0;
            rcnt_d  = '0;
`ifdef LCG_STIM_SIGNATURE_EN
            sig_d   = '0;
`endif
        end else begin
            case (state_q)
                RESET: begin
                    rcnt_d  = rcnt_q + 1'b1;
                    idx_d   = '0;
                    state_d = rcnt_q == RC_W'(RST_CYC - 1) ? FILL : RESET;
                end
                FILL: begin
                    rng_d     = rng_next;
                    in_flat_d = (in_flat_q & ~wr_mask) | wr_data;
                    idx_d     = idx_q + 1'b1;
                    state_d   = idx_q == IDX_W'(NWORDS - 1) ? APPLY : FILL;
                end
                APPLY: begin
`ifdef LCG_STIM_SIGNATURE_EN
                    sig_d   = {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]} ^ fold;
`endif
                    idx_d   = '0;
                    state_d = cnt_q == cyc_q ? DONE : FILL;
                    cnt_d   = cnt_q == cyc_q ? cnt_q : cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rng_q     <= '0;
            cyc_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            rcnt_q    <= '0;
            in_flat_q <= '0;
`ifdef LCG_STIM_SIGNATURE_EN
            sig_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rng_q     <= rng_d;
            cyc_q     <= cyc_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rcnt_q    <= rcnt_d;
            in_flat_q <= in_flat_d;
`ifdef LCG_STIM_SIGNATURE_EN
            sig_q     <= sig_d;
`endif
        end
    end

    assign in_flat   = in_flat_q;
    assign cyc_cnt   = cnt_q;
    assign vec_valid = state_q == APPLY;
    assign busy      = state_q == RESET || state_q == FILL || state_q == APPLY;
    assign done      = state_q == DONE;
    assign dut_rst_n = state_q == FILL || state_q == APPLY || state_q == DONE;
endmodule

// File: tb/tb_lcg_stim_sequencer.sv
// tb_lcg_stim_sequencer: scoreboard bench for lcg_stim_sequencer.
module tb_lcg_stim_sequencer;
    localparam int IN_W = 265, OUT_W = 330, CNT_W = 32, NW = 9;

    logic             clk = 0, rst_n = 0, start = 0, abort = 0;
    logic [31:0]      seed = 0;
    logic [CNT_W-1:0] cycles = 0;
    logic [OUT_W-1:0] out_flat = '0;
    logic [IN_W-1:0]  in_flat;
    logic             dut_rst_n, vec_valid, busy, done;
    logic [CNT_W-1:0] cyc_cnt;
    logic [31:0]      signature;

    int n_chk = 0, n_fail = 0, n_vec = 0;
    logic [IN_W-1:0]  exp_v[$];
    logic [CNT_W-1:0] exp_c[$];
    logic [31:0]      m_rng;

    always #5 clk = ~clk;

    lcg_stim_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
        .cycles(cycles), .out_flat(out_flat), .in_flat(in_flat), .dut_rst_n(dut_rst_n),
        .vec_valid(vec_valid), .cyc_cnt(cyc_cnt), .busy(busy), .done(done),
        .signature(signature)
    );

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic gen_vec(output logic [IN_W-1:0] v);
        logic [32*NW-1:0] w;
        for (int k = 0; k < NW; k++) begin
            m_rng = m_rng * 32'h41C64E6D + 32'h3039;
            w[32*k +: 32] = m_rng;
        end
        v = w[IN_W-1:0];
    endtask

    task automatic push_run(input logic [31:0] s, input int n);
        logic [IN_W-1:0] v;
        m_rng = s;
        for (int i = 0; i <= n; i++) begin
            gen_vec(v);
            exp_v.push_back(v);
            exp_c.push_back(CNT_W'(i));
        end
    endtask

    task automatic go(input logic [31:0] s, input logic [CNT_W-1:0] c);
        @(negedge clk);
        seed = s; cycles = c; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: done=%0b expected 1", nm, done);
        end
    endtask

    // Scoreboard monitor: every applied vector must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n && vec_valid) begin
            n_vec++;
            if (exp_v.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_vec: got cyc_cnt=%0d expected no vector", cyc_cnt);
            end else begin
                chk("vec_in_flat", 512'(in_flat), 512'(exp_v.pop_front()));
                chk("vec_cyc_cnt", 512'(cyc_cnt), 512'(exp_c.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int lat, lows, base, k;
        logic [IN_W-1:0] v4, v5;
        repeat (2) @(negedge clk);
        chk("rst_in_flat", 512'(in_flat), 512'(0));
        chk("rst_dut_rst_n", 512'(dut_rst_n), 512'(0));
        chk("rst_vec_valid", 512'(vec_valid), 512'(0));
        chk("rst_cyc_cnt", 512'(cyc_cnt), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_signature", 512'(signature), 512'(0));
        rst_n = 1;

        // T2: single vector from seed 0, latency and DUT reset width
        push_run(32'd0, 0);
        @(negedge clk);
        seed = 0; cycles = 0; start = 1;
        lat = 0; lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1 start = 0;
            lat++;
            if (!dut_rst_n) lows++;
            if (vec_valid) break;
        end
        chk("t2_latency", 512'(lat), 512'(12));
        chk("t2_dut_rst_low", 512'(lows), 512'(2));
        wait_done("t2", 50);
        chk("t2_word0", 512'(in_flat[31:0]), 512'(32'h00003039));
        chk("t2_word1", 512'(in_flat[63:32]), 512'(32'hD3DC167E));
        chk("t2_cyc_cnt", 512'(cyc_cnt), 512'(0));
        chk("t2_busy", 512'(busy), 512'(0));
        chk("t2_dut_rst_n", 512'(dut_rst_n), 512'(1));

        // T1: async reset mid-FILL
        go(32'h1234, 10);
        repeat (4) @(negedge clk);
        chk("t1_busy_before", 512'(busy), 512'(1));
        #2 rst_n = 0;
        #1;
        chk("t1_in_flat", 512'(in_flat), 512'(0));
        chk("t1_dut_rst_n", 512'(dut_rst_n), 512'(0));
        chk("t1_busy", 512'(busy), 512'(0));
        chk("t1_done", 512'(done), 512'(0));
        chk("t1_cyc_cnt", 512'(cyc_cnt), 512'(0));
        chk("t1_vec_valid", 512'(vec_valid), 512'(0));
        @(negedge clk);
        rst_n = 1;

        // T3: long run
        push_run(32'd13242637, 300);
        base = n_vec;
        go(32'd13242637, 300);
        wait_done("t3", 4000);
        chk("t3_cyc_cnt", 512'(cyc_cnt), 512'(300));
        chk("t3_pulses", 512'(n_vec - base), 512'(301));
        chk("t3_top_bits", 512'(in_flat[264:256]), 512'(m_rng[8:0]));
        chk("t3_queue", 512'(exp_v.size()), 512'(0));

        // T4: abort at 3rd FILL clock of vector 5
        push_run(32'hCAFEF00D, 3);
        v4 = exp_v[$];
        gen_vec(v5);
        go(32'hCAFEF00D, 20);
        k = 0;
        for (int i = 0; i < 200 && k < 4; i++) begin
            @(negedge clk);
            if (vec_valid) k++;
        end
        chk("t4_pulses", 512'(k), 512'(4));
        repeat (3) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("t4_busy", 512'(busy), 512'(0));
        chk("t4_done", 512'(done), 512'(0));
        chk("t4_dut_rst_n", 512'(dut_rst_n), 512'(0));
        chk("t4_cyc_cnt", 512'(cyc_cnt), 512'(4));
        chk("t4_in_flat", 512'(in_flat), 512'({v4[IN_W-1:64], v5[63:0]}));
        push_run(32'h00005EED, 1);
        go(32'h00005EED, 1);
        wait_done("t4b", 100);
        chk("t4_rerun_cnt", 512'(cyc_cnt), 512'(1));
        chk("t4_queue", 512'(exp_v.size()), 512'(0));

        // T5: start during FILL ignored, start in DONE re-runs
        push_run(32'h777, 5);
        base = n_vec;
        go(32'h777, 5);
        repeat (5) @(negedge clk);
        seed = 32'hDEAD; cycles = 0; start = 1;
        @(negedge clk);
        start = 0;
        wait_done("t5", 200);
        chk("t5_cyc_cnt", 512'(cyc_cnt), 512'(5));
        chk("t5_pulses", 512'(n_vec - base), 512'(6));
        push_run(32'h99, 0);
        go(32'h99, 0);
        wait_done("t5b", 50);
        chk("t5_rerun_cnt", 512'(cyc_cnt), 512'(0));
        chk("t5_queue", 512'(exp_v.size()), 512'(0));

        // T6: signature with zero and non-zero responses
        out_flat = '0;
        push_run(32'd1, 3);
        go(32'd1, 3);
        wait_done("t6a", 100);
        chk("t6_sig_zero", 512'(signature), 512'(0));
        out_flat[0] = 1'b1;
        out_flat[321:320] = 2'b11;
        push_run(32'd2, 3);
        go(32'd2, 3);
        wait_done("t6b", 100);
`ifdef LCG_STIM_SIGNATURE_EN
        chk("t6_sig_misr", 512'(signature), 512'(32'h0000001A));
`else
        chk("t6_sig_off", 512'(signature), 512'(0));
`endif
        chk("final_queue", 512'(exp_v.size()), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
